// File: rtl/c3dfx_tcm_pulse_seq_if.sv
// Control/status bundle between the DFX controller and one pulse sequencer.
// The sequencer takes the slave view; the controller (or bench) takes the master view.
interface c3dfx_tcm_pulse_seq_if #(
    parameter int CNT_W = 8
);
    logic             i_start;
    logic             i_scan_enable;
    logic             i_abort;
    logic [2:0]       i_num_pulses;
    logic [CNT_W-1:0] i_settle_cyc;
    logic [CNT_W-1:0] i_gap_cyc;
    logic             o_func_clken;
    logic             o_busy;
    logic             o_done;
    logic             o_err;
    logic [2:0]       o_pulse_cnt;

    modport slave (
        input  i_start, i_scan_enable, i_abort, i_num_pulses, i_settle_cyc, i_gap_cyc,
        output o_func_clken, o_busy, o_done, o_err, o_pulse_cnt
    );

    modport master (
        output i_start, i_scan_enable, i_abort, i_num_pulses, i_settle_cyc, i_gap_cyc,
        input  o_func_clken, o_busy, o_done, o_err, o_pulse_cnt
    );
endinterface

// File: rtl/c3dfx_tcm_pulse_seq.sv
// At-speed launch/capture sequencer: emits a burst of single-cycle functional clock
// enables for the test clock macro, framed by settle intervals and separated by gaps.
module c3dfx_tcm_pulse_seq #(
    parameter int PULSE_MAX = 4,
    parameter int CNT_W     = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    c3dfx_tcm_pulse_seq_if.slave     bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_PULSE  = 3'd2,
        ST_GAP    = 3'd3,
        ST_POST   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam logic [2:0]       PULSE_MAX_L = 3'(PULSE_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           state_reg,  state_next;
    logic [CNT_W-1:0] cnt_reg,    cnt_next;
    logic [CNT_W-1:0] settle_reg, settle_next;
    logic [CNT_W-1:0] gap_reg,    gap_next;
    logic [2:0]       num_reg,    num_next;
    logic [2:0]       pcnt_reg,   pcnt_next;
    logic             clken_reg,  clken_next;
    logic             done_reg,   done_next;
    logic             err_reg,    err_next;

    logic             abort_req;
    logic [2:0]       num_clamped;
    logic [2:0]       pcnt_inc;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            settle_reg <= '0;
            gap_reg    <= '0;
            num_reg    <= '0;
            pcnt_reg   <= '0;
            clken_reg  <= 1'b0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            settle_reg <= settle_next;
            gap_reg    <= gap_next;
            num_reg    <= num_next;
            pcnt_reg   <= pcnt_next;
            clken_reg  <= clken_next;
            done_reg   <= done_next;
            err_reg    <= err_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        settle_next = settle_reg;
        gap_next    = gap_reg;
        num_next    = num_reg;
        pcnt_next   = pcnt_reg;
        clken_next  = 1'b0;
        done_next   = 1'b0;
        err_next    = 1'b0;

        abort_req   = (bus.i_abort || bus.i_scan_enable) &&
                      (state_reg != ST_IDLE) && (state_reg != ST_DONE);
        num_clamped = (bus.i_num_pulses > PULSE_MAX_L) ? PULSE_MAX_L : bus.i_num_pulses;
        pcnt_inc    = pcnt_reg + 3'd1;

        // An abort overrides whatever the current state would have done; a pulse
        // cut off this way is neither driven nor counted.
        if (abort_req) begin
            state_next = ST_IDLE;
            err_next   = 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        if (bus.i_scan_enable || (bus.i_num_pulses == 3'd0)) begin
                            err_next = 1'b1;
                        end else begin
                            num_next    = num_clamped;
                            settle_next = bus.i_settle_cyc;
                            gap_next    = bus.i_gap_cyc;
                            pcnt_next   = 3'd0;
                            cnt_next    = bus.i_settle_cyc;
                            state_next  = ST_SETTLE;
                        end
                    end
                end

                ST_SETTLE: begin
                    if (cnt_reg == '0) begin
                        state_next = ST_PULSE;
                    end else begin
                        cnt_next = cnt_reg - CNT_ONE;
                    end
                end

                ST_PULSE: begin
                    clken_next = 1'b1;
                    pcnt_next  = pcnt_inc;
                    if (pcnt_inc < num_reg) begin
                        if (gap_reg == '0) begin
                            state_next = ST_PULSE;
                        end else begin
                            cnt_next   = gap_reg;
                            state_next = ST_GAP;
                        end
                    end else begin
                        cnt_next   = settle_reg;
                        state_next = ST_POST;
                    end
                end

                // The gap value is the number of low enable cycles between pulses,
                // so the state is left one count earlier than settle/post.
                ST_GAP: begin
                    if (cnt_reg <= CNT_ONE) begin
                        state_next = ST_PULSE;
                    end else begin
                        cnt_next = cnt_reg - CNT_ONE;
                    end
                end

                ST_POST: begin
                    if (cnt_reg == '0) begin
                        state_next = ST_DONE;
                    end else begin
                        cnt_next = cnt_reg - CNT_ONE;
                    end
                end

                ST_DONE: begin
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end

                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_func_clken = clken_reg;
    assign bus.o_busy       = (state_reg != ST_IDLE);
    assign bus.o_done       = done_reg;
    assign bus.o_err        = err_reg;
    assign bus.o_pulse_cnt  = pcnt_reg;

endmodule

// File: tb/tb_c3dfx_tcm_pulse_seq.sv
// Directed bench for the TCM pulse sequencer: stimulus queues expected output
// samples per cycle, a negedge monitor compares and flags any unplanned activity.
module tb_c3dfx_tcm_pulse_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    c3dfx_tcm_pulse_seq_if #(.CNT_W(8)) bus();

    c3dfx_tcm_pulse_seq #(.PULSE_MAX(4), .CNT_W(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        int         cyc;
        logic       clken;
        logic       done;
        logic       err;
        logic       busy;
        logic [2:0] pcnt;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [6:0] act_vec;
    logic [6:0] req_vec;
    exp_t       head;

    task automatic push(input int c, input logic clken, input logic done,
                        input logic err, input logic busy, input logic [2:0] pcnt);
        exp_t e;
        e.cyc = c; e.clken = clken; e.done = done; e.err = err; e.busy = busy; e.pcnt = pcnt;
        exp_q.push_back(e);
    endtask

    // Monitor: a queued entry for this cycle is compared whether or not the DUT
    // shows activity; activity with no entry is an unexpected event.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            head = exp_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL missing_sample cyc=%0d: no comparison made, required at cyc=%0d", cyc, head.cyc);
        end
        act_vec = {bus.o_func_clken, bus.o_done, bus.o_err, bus.o_busy, bus.o_pulse_cnt};
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            head = exp_q.pop_front();
            req_vec = {head.clken, head.done, head.err, head.busy, head.pcnt};
            n_checks++;
            if (act_vec !== req_vec) begin
                n_fail++;
                $display("FAIL sample cyc=%0d: got clken=%b done=%b err=%b busy=%b pcnt=%0d, required clken=%b done=%b err=%b busy=%b pcnt=%0d",
                         cyc, act_vec[6], act_vec[5], act_vec[4], act_vec[3], act_vec[2:0],
                         req_vec[6], req_vec[5], req_vec[4], req_vec[3], req_vec[2:0]);
            end else begin
                $display("ok  cyc=%0d clken=%b done=%b err=%b busy=%b pcnt=%0d",
                         cyc, act_vec[6], act_vec[5], act_vec[4], act_vec[3], act_vec[2:0]);
            end
        end else if (bus.o_func_clken === 1'b1 || bus.o_done === 1'b1 || bus.o_err === 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event cyc=%0d: got clken=%b done=%b err=%b, required all 0",
                     cyc, bus.o_func_clken, bus.o_done, bus.o_err);
        end
    end

    // Expected timing: first enable at start edge T + settle + 2, later pulses every
    // gap+1 cycles, done at last enable + settle + 2, abort error one cycle after request.
    task automatic burst(input int num, input int s, input int g,
                         input int abort_after, input bit use_scan);
        int t;
        int n;
        int c;
        int last;
        @(negedge clk);
        bus.i_start      = 1'b1;
        bus.i_num_pulses = 3'(num);
        bus.i_settle_cyc = 8'(s);
        bus.i_gap_cyc    = 8'(g);
        t = cyc + 1;
        n = (num > 4) ? 4 : num;
        push(t, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
        last = t;
        for (int i = 1; i <= n; i++) begin
            if (abort_after == 0 || i <= abort_after) begin
                c = t + s + 2 + (i - 1) * (g + 1);
                push(c, 1'b1, 1'b0, 1'b0, 1'b1, 3'(i));
                last = c;
            end
        end
        if (abort_after != 0)
            push(last + 1, 1'b0, 1'b0, 1'b1, 1'b0, 3'(abort_after));
        else
            push(last + s + 2, 1'b0, 1'b1, 1'b0, 1'b0, 3'(n));
        @(negedge clk);
        bus.i_start = 1'b0;
        if (abort_after != 0) begin
            while (cyc < last) @(negedge clk);
            if (use_scan) bus.i_scan_enable = 1'b1;
            else          bus.i_abort       = 1'b1;
            @(negedge clk);
            bus.i_scan_enable = 1'b0;
            bus.i_abort       = 1'b0;
        end
        while (cyc < last + s + 4) @(negedge clk);
    endtask

    task automatic reject(input int num, input bit scan, input logic [2:0] pcnt_prev);
        int t;
        @(negedge clk);
        bus.i_start       = 1'b1;
        bus.i_scan_enable = scan;
        bus.i_num_pulses  = 3'(num);
        bus.i_settle_cyc  = 8'd1;
        bus.i_gap_cyc     = 8'd0;
        t = cyc + 1;
        push(t,     1'b0, 1'b0, 1'b1, 1'b0, pcnt_prev);
        push(t + 1, 1'b0, 1'b0, 1'b0, 1'b0, pcnt_prev);
        @(negedge clk);
        bus.i_start       = 1'b0;
        bus.i_scan_enable = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int t;
        bus.i_start       = 1'b0;
        bus.i_scan_enable = 1'b0;
        bus.i_abort       = 1'b0;
        bus.i_num_pulses  = 3'd0;
        bus.i_settle_cyc  = 8'd0;
        bus.i_gap_cyc     = 8'd0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        push(cyc + 1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        burst(2, 3, 0, 0, 1'b0);   // enables at T+5,T+6, done at T+11
        burst(3, 0, 2, 0, 1'b0);   // enables at T+2,T+5,T+8, done at T+10
        reject(2, 1'b1, 3'd3);     // start while scanning
        reject(0, 1'b0, 3'd3);     // zero pulses requested
        burst(7, 1, 1, 0, 1'b0);   // clamped to 4 pulses
        burst(4, 0, 5, 2, 1'b0);   // abort after 2nd pulse
        burst(4, 0, 5, 2, 1'b1);   // scan enable rising mid-burst

        // Reset while in GAP, then a fresh burst
        @(negedge clk);
        bus.i_start      = 1'b1;
        bus.i_num_pulses = 3'd3;
        bus.i_settle_cyc = 8'd0;
        bus.i_gap_cyc    = 8'd4;
        t = cyc + 1;
        push(t,     1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
        push(t + 2, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1);
        push(t + 4, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        @(negedge clk);
        bus.i_start = 1'b0;
        while (cyc < t + 3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        burst(1, 2, 0, 0, 1'b0);   // enable at T+4, done at T+8

        repeat (10) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule
